// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data responder serving loads/stores from a word RAM plus LED/switch MMIO.
module dmem_responder #(
    parameter int          DEPTH    = 16384,
    parameter logic [31:0] LED_ADDR = 32'hFFFFFC60,
    parameter logic [31:0] SW_ADDR  = 32'hFFFFFC70
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, RESP} stateT;

    stateT         state, stateNext;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   ramQ;
    logic [AW-1:0] reqIdx, aIdx, wIdx;
    logic [1:0]    aLane, aSize;
    logic          aUns;
    logic [15:0]   aWdata, swMeta, swSync;
    logic          inRam, isLed, isSw, reqErr;
    logic          respLoad, respErrNext, ramWe, ledWe;
    logic [31:0]   respDataNext, wData, loadExt, merged, laneMask;
    logic [4:0]    laneShift;
    logic [7:0]    byteV;
    logic [15:0]   halfV;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign reqIdx     = req_addr[AW+1:2];
    assign inRam      = (req_addr >> (AW + 2)) == 32'd0;
    assign isLed      = req_addr == LED_ADDR;
    assign isSw       = req_addr == SW_ADDR;
    assign reqErr     = req_size == 2'b11
                      || (req_size == 2'b01 && req_addr[0])
                      || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                      || !(inRam || isLed || isSw)
                      || ((isLed || isSw) && req_size != 2'b10)
                      || (isSw && req_we);

    assign byteV     = ramQ[{aLane, 3'b000} +: 8];
    assign halfV     = aLane[1] ? ramQ[31:16] : ramQ[15:0];
    assign loadExt   = aSize == 2'b00 ? {{24{~aUns & byteV[7]}}, byteV}
                     : aSize == 2'b01 ? {{16{~aUns & halfV[15]}}, halfV} : ramQ;
    assign laneMask  = aSize == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF;
    assign laneShift = aSize == 2'b00 ? {aLane, 3'b000} : {aLane[1], 4'b0000};
    assign merged    = (ramQ & ~(laneMask << laneShift)) | (({16'b0, aWdata} & laneMask) << laneShift);

    always_comb begin
        stateNext    = state;
        respLoad     = 1'b0;
        respDataNext = 32'd0;
        respErrNext  = 1'b0;
        ramWe        = 1'b0;
        ledWe        = 1'b0;
        wIdx         = reqIdx;
        wData        = req_wdata;
        case (state)
            IDLE: if (req_valid) begin
                if (reqErr) begin
                    stateNext   = RESP;
                    respLoad    = 1'b1;
                    respErrNext = 1'b1;
                end else if (inRam) begin
                    stateNext = !req_we ? RD_WAIT : req_size == 2'b10 ? RESP : RMW_RD;
                    respLoad  = req_we && req_size == 2'b10;
                    ramWe     = req_we && req_size == 2'b10;
                end else begin
                    stateNext    = RESP;
                    respLoad     = 1'b1;
                    ledWe        = req_we;
                    respDataNext = req_we ? 32'd0 : {16'd0, isLed ? led_out : swSync};
                end
            end
            RD_WAIT: begin
                stateNext    = RESP;
                respLoad     = 1'b1;
                respDataNext = loadExt;
            end
            RMW_RD: stateNext = RMW_WR;
            RMW_WR: begin
                stateNext = RESP;
                respLoad  = 1'b1;
                ramWe     = 1'b1;
                wIdx      = aIdx;
                wData     = merged;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            led_out    <= 16'd0;
            swMeta     <= 16'd0;
            swSync     <= 16'd0;
        end else begin
            state  <= stateNext;
            swMeta <= sw_in;
            swSync <= swMeta;
            if (respLoad) begin
                resp_rdata <= respDataNext;
                resp_err   <= respErrNext;
            end
            if (ledWe) led_out <= req_wdata[15:0];
        end
    end

    // RAM and request latch carry no reset; a write is dropped if reset lands on its edge
    always_ff @(posedge clk) begin
        if (ramWe && rst) mem[wIdx] <= wData;
        ramQ <= mem[state == IDLE ? reqIdx : aIdx];
        if (state == IDLE) begin
            aIdx   <= reqIdx;
            aLane  <= req_addr[1:0];
            aSize  <= req_size;
            aUns   <= req_unsigned;
            aWdata <= req_wdata[15:0];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table plus hand sequences for handshake and reset-abort cases.
module tb_dmem_responder;
    localparam logic [31:0] LED = 32'hFFFFFC60;
    localparam logic [31:0] SW  = 32'hFFFFFC70;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [15:0] sw_in = 16'd0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] led_out;
    int total = 0, bad = 0;

    dmem_responder dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .sw_in(sw_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [15:0] led;
    } vecT;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic issue(input string nm, input vecT v);
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.sz; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wd;
        chk({nm, " ready_idle"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({nm, " ready_busy"}, 32'(req_ready), 32'd0);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({nm, " rdata"}, resp_rdata, v.rd);
        chk({nm, " err"}, 32'(resp_err), 32'(v.err));
        @(posedge clk); #1;
        chk({nm, " ready_after"}, 32'(req_ready), 32'd1);
        chk({nm, " single_pulse"}, 32'(resp_valid), 32'd0);
        chk({nm, " rdata_hold"}, resp_rdata, v.rd);
        chk({nm, " led"}, 32'(led_out), 32'(v.led));
    endtask

    vecT tbl[$];
    vecT one;
    int  c;

    initial begin
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h40,       32'hDEADBEEF, 32'h0,        1'b0, 1, 16'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        32'hDEADBEEF, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h41,       32'h12345680, 32'h0,        1'b0, 3, 16'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        32'hDEAD80EF, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h41,       32'h0,        32'hFFFFFF80, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h41,       32'h0,        32'h00000080, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h42,       32'h0,        32'hFFFFDEAD, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h40,       32'h0,        32'h000080EF, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h42,       32'hFFFF1234, 32'h0,        1'b0, 3, 16'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        32'h123480EF, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h43,       32'h0,        32'h00000012, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h40,       32'h0,        32'hFFFFFFEF, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h44,       32'h0BADF00D, 32'h0,        1'b0, 1, 16'h0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'hFFFC,     32'h600DCAFE, 32'h0,        1'b0, 1, 16'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'hFFFC,     32'h0,        32'h600DCAFE, 1'b0, 2, 16'h0});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h43,       32'h0,        32'h0,        1'b1, 1, 16'h0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h46,       32'h77777777, 32'h0,        1'b1, 1, 16'h0});
        tbl.push_back('{1'b0, 2'b11, 1'b0, 32'h40,       32'h0,        32'h0,        1'b1, 1, 16'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h00100000, 32'h0,        32'h0,        1'b1, 1, 16'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h00010000, 32'h0,        32'h0,        1'b1, 1, 16'h0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, SW,           32'h0000FFFF, 32'h0,        1'b1, 1, 16'h0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, LED,          32'h0001A5A5, 32'h0,        1'b0, 1, 16'hA5A5});
        tbl.push_back('{1'b0, 2'b10, 1'b0, LED,          32'h0,        32'h0000A5A5, 1'b0, 1, 16'hA5A5});
        tbl.push_back('{1'b1, 2'b01, 1'b0, LED,          32'h00000000, 32'h0,        1'b1, 1, 16'hA5A5});
        tbl.push_back('{1'b0, 2'b00, 1'b0, SW,           32'h0,        32'h0,        1'b1, 1, 16'hA5A5});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        32'h123480EF, 1'b0, 2, 16'hA5A5});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h44,       32'h0,        32'h0BADF00D, 1'b0, 2, 16'hA5A5});

        repeat (2) @(posedge clk);
        #1;
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset rdata", resp_rdata, 32'd0);
        chk("reset err", 32'(resp_err), 32'd0);
        chk("reset led", 32'(led_out), 32'd0);
        chk("reset ready", 32'(req_ready), 32'd1);
        @(negedge clk) rst = 1'b1;

        foreach (tbl[i]) issue($sformatf("vec%0d", i), tbl[i]);

        // switch value must show up after the two-flop synchronizer
        @(negedge clk) sw_in = 16'h1234;
        @(posedge clk);
        @(posedge clk);
        issue("sw_load", '{1'b0, 2'b10, 1'b0, SW, 32'h0, 32'h00001234, 1'b0, 1, 16'hA5A5});

        // busy-period request changes must be ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
        @(posedge clk); #1;
        c = 1;
        while (!resp_valid && c < 10) begin
            @(negedge clk);
            req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h5555AAAA + c;
            @(posedge clk); #1;
            c++;
        end
        chk("hs latency", 32'(c), 32'd2);
        chk("hs rdata", resp_rdata, 32'h123480EF);
        @(negedge clk) req_valid = 1'b0;
        @(posedge clk); #1;
        chk("hs ready_after", 32'(req_ready), 32'd1);
        chk("hs single_pulse", 32'(resp_valid), 32'd0);
        issue("hs ignored_store", '{1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 1'b0, 2, 16'hA5A5});

        // reset during RMW_WR: no write, no response
        issue("pre_rmw", '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1, 16'hA5A5});
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("abort resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("abort resp_valid2", 32'(resp_valid), 32'd0);
        chk("abort led", 32'(led_out), 32'd0);
        chk("abort ready", 32'(req_ready), 32'd1);
        chk("abort err", 32'(resp_err), 32'd0);
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort no_pulse", 32'(resp_valid), 32'd0);
        end
        issue("post_abort", '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 2, 16'h0});

        one = tbl[0];
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
